pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Controller that sequences parallel words through the serial "1100" detector (fsm_1100). It accepts one WORD_W-bit word per valid/ready handshake and shifts it MSB-first into the detector, one bit per cycle. It counts detections and reports a per-word result with a done pulse. It sits between a word-oriented producer and the bit-serial detector, which it owns exclusively.

## Interface
- WORD_W, 16: bits per scanned word; must be ≥4.
- CNT_W, 3: width of match_count; saturating.
- IDX_W, $clog2(WORD_W): width of first_idx.

- clk  in  1  rising-edge clock, single domain.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_word  in  WORD_W  word to scan; bit WORD_W-1 is sent first.
- busy  out  1  high in SHIFT and FLUSH.
- done  out  1  one-cycle pulse; results valid in that cycle and held until the next accept.
- match_count  out  CNT_W  detections in the last word, saturating at 2^CNT_W-1.
- match_found  out  1  at least one detection in the last word.
- first_idx  out  IDX_W  scan index (0 = first bit sent) of the final '0' of the first match; 0 when match_found=0.

## Operation
- States: IDLE, SHIFT, FLUSH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_word into the shift register.
  - Clear the bit index, match_count, match_found and first_idx.
  - Clear the detector state (see Configuration).
  - Go to SHIFT.
- SHIFT:
  - Drive shift-register MSB to the detector bit input; shift left by 1 each cycle.
  - Bit index runs 0..WORD_W-1.
  - After index WORD_W-1, go to FLUSH.
- FLUSH: one cycle to capture the detection caused by the final bit. Go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Detector contract: registered output. pattern_detected is high in the cycle after the fourth pattern bit is presented. The detector restarts after each match, so 11001100 gives 2 matches.
- Capture:
  - In SHIFT (index ≥1) or FLUSH, a high pattern_detected is attributed to scan index k = current index − 1 (WORD_W-1 in FLUSH).
  - Each such cycle increments match_count, saturating.
  - The first such cycle sets match_found=1 and first_idx=k.
- in_valid outside IDLE is ignored; the producer holds its word until in_ready.
- rst=0 in any cycle: next state IDLE, detector cleared, all outputs at reset values. An in-flight word is discarded.
- Reset values: in_ready=1 (IDLE), busy=0, done=0, match_count=0, match_found=0, first_idx=0.

## Timing
- Accept edge = cycle 0. Bits are presented in cycles 1..WORD_W, FLUSH is cycle WORD_W+1, done is high in cycle WORD_W+2.
- in_ready returns high in cycle WORD_W+3. Throughput is one word per WORD_W+3 cycles.
- Back-to-back: an accept in the first IDLE cycle after DONE is legal.
- All outputs are registered except in_ready and busy, which are decoded from state.

## Configuration
- PATTERN_SCAN_CARRY_EN:
  - Defined: the detector is not cleared on accept. Its state carries across consecutive words, so a pattern spanning a word boundary is detected and counted in the later word. Only rst clears the detector.
  - Undefined: the detector is cleared on every accept, so each word is scanned independently.

## Structure
- Package pattern_scan_pkg holds the state enum typedef (IDLE, SHIFT, FLUSH, DONE) and the pattern length constant (4).
- One sub-module: fsm_1100, instantiated once.
  - Detector reset = rst AND NOT clear_pulse.
  - clear_pulse is forced to 0 under PATTERN_SCAN_CARRY_EN.

## Test plan
All cases use WORD_W=16, CNT_W=3 unless noted.
- in_word=16'hC000 -> done at cycle 18, match_count=1, match_found=1, first_idx=3.
- in_word=16'hCCCC -> match_count=4, first_idx=3.
- in_word=16'h0000 -> match_count=0, match_found=0, first_idx=0.
- With CNT_W=2, in_word=16'hCCCC -> match_count saturates at 3, first_idx=3.
- Send 16'h0003 then 16'h3FFF back-to-back:
  - With PATTERN_SCAN_CARRY_EN: second word gives match_count=1, first_idx=1.
  - Without the macro: second word gives match_count=0.
- Reset and handshake:
  - rst=0 at cycle 5 of a 16'hCCCC scan -> next cycle in_ready=1, busy=0, match_count=0, with no done pulse.
  - in_valid held high while busy -> no second accept before in_ready.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan controller and its
// bit-serial "1100" detector.
package pattern_scan_pkg;

  // Length of the detected pattern "1100".
  localparam int PATTERN_LEN = 4;

  // Detector needs one state per matched prefix length (0..3 bits).
  localparam int DET_W = $clog2(PATTERN_LEN);

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Detector states: how much of "1100" has been seen so far.
  typedef enum logic [DET_W-1:0] {
    DET_NONE = 2'd0,
    DET_1    = 2'd1,
    DET_11   = 2'd2,
    DET_110  = 2'd3
  } det_state_t;

  // Debug view of both state machines.
  typedef struct packed {
    state_t     ctrl;
    det_state_t det;
  } dbg_t;

endpackage

// File: rtl/fsm_1100.sv
// Bit-serial "1100" detector. One bit is consumed per cycle when
// i_bit_valid is high; o_pattern_detected is a registered pulse in the
// cycle after the fourth pattern bit. After a match the search restarts
// from scratch, so matches never share bits.
module fsm_1100
  import pattern_scan_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bit_valid,
  input  logic       i_bit,
  output logic       o_pattern_detected,
  output det_state_t o_dbg_state
);

  det_state_t r_state;
  logic       r_detected;

  // Prefix-tracking FSM with a registered match pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= DET_NONE;
      r_detected <= 1'b0;
    end else begin
      r_detected <= 1'b0;
      if (i_bit_valid) begin
        case (r_state)
          DET_NONE: r_state <= i_bit ? DET_1 : DET_NONE;
          DET_1:    r_state <= i_bit ? DET_11 : DET_NONE;
          DET_11:   r_state <= i_bit ? DET_11 : DET_110;
          DET_110: begin
            if (i_bit) begin
              r_state <= DET_1;
            end else begin
              r_state    <= DET_NONE;
              r_detected <= 1'b1;
            end
          end
          default:  r_state <= DET_NONE;
        endcase
      end
    end
  end

  assign o_pattern_detected = r_detected;
  assign o_dbg_state        = r_state;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencer for the fsm_1100 detector. Accepts a word,
// shifts it MSB-first into the detector, counts matches and reports a
// per-word result with a one-cycle done pulse.
//
// Handshake: a word transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE and the producer
// keeps in_valid/in_word stable until that transfer.
//
// Build option PATTERN_SCAN_CARRY_EN: when defined, the detector keeps its
// state across words (only rst clears it), so a pattern straddling a word
// boundary counts in the later word. When undefined, every accept clears
// the detector and each word is scanned on its own.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 3,
  parameter int IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count,
  output logic              match_found,
  output logic [IDX_W-1:0]  first_idx,
  output dbg_t              dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              r_state;
  logic [WORD_W-1:0]   r_shift;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_count;
  logic                r_found;
  logic [IDX_W-1:0]    r_first;
  logic                r_done;

  logic                w_accept;
  logic                w_clear;
  logic                w_det_rst_n;
  logic                w_detected;
  logic                w_capture;
  logic [IDX_W-1:0]    w_k;
  det_state_t          w_det_state;

  assign w_accept = (r_state == IDLE) && in_valid;

`ifdef PATTERN_SCAN_CARRY_EN
  assign w_clear = 1'b0;
`else
  assign w_clear = w_accept;
`endif

  assign w_det_rst_n = rst && !w_clear;

  // The detector answers one cycle late, so a hit seen now belongs to the
  // previous scan index; in FLUSH that is the last bit of the word.
  assign w_capture = w_detected &&
                     (((r_state == SHIFT) && (r_idx != '0)) || (r_state == FLUSH));
  assign w_k       = (r_state == FLUSH) ? LAST_IDX : (r_idx - IDX_W'(1));

  fsm_1100 u_det (
    .i_clk              (clk),
    .i_rst_n            (w_det_rst_n),
    .i_bit_valid        (r_state == SHIFT),
    .i_bit              (r_shift[WORD_W-1]),
    .o_pattern_detected (w_detected),
    .o_dbg_state        (w_det_state)
  );

  // Sequencing FSM with registered results and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_found <= 1'b0;
      r_first <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= in_word;
            r_idx   <= '0;
            r_count <= '0;
            r_found <= 1'b0;
            r_first <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_capture) begin
        if (r_count != CNT_MAX) begin
          r_count <= r_count + CNT_W'(1);
        end
        if (!r_found) begin
          r_found <= 1'b1;
          r_first <= w_k;
        end
      end
    end
  end

  assign in_ready        = (r_state == IDLE);
  assign busy            = (r_state == SHIFT) || (r_state == FLUSH);
  assign done            = r_done;
  assign match_count     = r_count;
  assign match_found     = r_found;
  assign first_idx       = r_first;
  assign dbg_state.ctrl  = r_state;
  assign dbg_state.det   = w_det_state;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: table-driven known words,
// hand-written multi-cycle sequences (back-to-back, mid-scan reset,
// held in_valid) and random words against a bit-history reference model.
module tb_pattern_scan_ctrl;
  import pattern_scan_pkg::*;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 3;
  localparam int IDX_W  = 4;
  localparam int EXP_W  = CNT_W + 1 + IDX_W + 2;

`ifdef PATTERN_SCAN_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [WORD_W-1:0] in_word;

  logic              in_ready, busy, done, match_found;
  logic [CNT_W-1:0]  match_count;
  logic [IDX_W-1:0]  first_idx;
  dbg_t              dbg_a;

  logic              in_ready_b, busy_b, done_b, match_found_b;
  logic [1:0]        match_count_b;
  logic [IDX_W-1:0]  first_idx_b;
  dbg_t              dbg_b;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .busy(busy), .done(done), .match_count(match_count),
    .match_found(match_found), .first_idx(first_idx), .dbg_state(dbg_a)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_word(in_word), .busy(busy_b), .done(done_b), .match_count(match_count_b),
    .match_found(match_found_b), .first_idx(first_idx_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: keep the bits seen since the last match (or clear); a match
  // is the history ending in 1,1,0,0, after which history starts over.
  task automatic model_word(input logic [WORD_W-1:0] w, output logic [EXP_W-1:0] e);
    int cnt;
    int first;
    bit found;
    cnt = 0; first = 0; found = 1'b0;
    if (!CARRY) hist.delete();
    for (int i = 0; i < WORD_W; i++) begin
      hist.push_back(w[WORD_W-1-i]);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist[0] && hist[1] && !hist[2] && !hist[3]) begin
        if (!found) first = i;
        found = 1'b1;
        cnt++;
        hist.delete();
      end
    end
    e = {CNT_W'(cnt > 7 ? 7 : cnt), found, IDX_W'(first), 2'(cnt > 3 ? 3 : cnt)};
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    hist.delete();
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called one step after a rising edge with the DUT in IDLE. Holds
  // in_valid for the whole scan to show it is ignored while busy; returns
  // results sampled in the done cycle and checks timing/handshake.
  task automatic scan_word(input string tag, input logic [WORD_W-1:0] w,
                           output logic [EXP_W-1:0] got);
    int  done_cyc;
    int  pulses;
    bit  hs_ok;
    logic [EXP_W-1:0] held;
    done_cyc = -1; pulses = 0; hs_ok = 1'b1;
    got = 'x;
    in_valid = 1'b1;
    in_word  = w;
    @(posedge clk); #1;
    for (int c = 1; c <= WORD_W + 2; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) hs_ok = 1'b0;
      if (busy !== (c <= WORD_W + 1)) hs_ok = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        done_cyc = c;
        got = {match_count, match_found, first_idx, match_count_b};
      end
      @(posedge clk); #1;
    end
    if (pulses != 1) done_cyc = -pulses - 1;
    check({tag, "_done_cycle"}, done_cyc, WORD_W + 2);
    check({tag, "_busy_handshake"}, hs_ok, 1);
    check({tag, "_ready_return"}, in_ready, 1);
    held = {match_count, match_found, first_idx, match_count_b};
    check({tag, "_result_held"}, held, got);
    in_valid = 1'b0;
  endtask

  task automatic compare_result(input string tag, input logic [EXP_W-1:0] got,
                                input logic [EXP_W-1:0] e);
    check({tag, "_count"}, got[EXP_W-1 -: CNT_W], e[EXP_W-1 -: CNT_W]);
    check({tag, "_found"}, got[IDX_W+2], e[IDX_W+2]);
    check({tag, "_first_idx"}, got[IDX_W+1:2], e[IDX_W+1:2]);
    check({tag, "_count_sat"}, got[1:0], e[1:0]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WORD_W-1:0] word;
    int cnt;
    bit found;
    int idx;
    int cnt_sat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] e;
    int pulses;

    vecs[0] = '{16'hC000, 1, 1'b1, 3, 1};
    vecs[1] = '{16'hCCCC, 4, 1'b1, 3, 3};
    vecs[2] = '{16'h0000, 0, 1'b0, 0, 0};
    vecs[3] = '{16'h3333, 3, 1'b1, 5, 3};
    vecs[4] = '{16'h000C, 1, 1'b1, 15, 1};
    vecs[5] = '{16'hFFFF, 0, 1'b0, 0, 0};

    rst = 1'b0; in_valid = 1'b0; in_word = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_match_count", match_count, 0);
    check("reset_match_found", match_found, 0);
    check("reset_first_idx", first_idx, 0);
    @(posedge clk); #1;

    // Known words, each from a clean detector.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      scan_word($sformatf("vec%0d", i), vecs[i].word, got);
      e = {CNT_W'(vecs[i].cnt), vecs[i].found, IDX_W'(vecs[i].idx), 2'(vecs[i].cnt_sat)};
      compare_result($sformatf("vec%0d", i), got, e);
    end

    // Back-to-back words; the boundary-spanning "1100" only counts with carry.
    do_reset();
    scan_word("b2b_first", 16'h0003, got);
    scan_word("b2b_second", 16'h3FFF, got);
    e = CARRY ? {CNT_W'(1), 1'b1, IDX_W'(1), 2'd1} : {CNT_W'(0), 1'b0, IDX_W'(0), 2'd0};
    compare_result("b2b_second", got, e);

    // Reset in cycle 5 of a scan: in-flight word is dropped, no done.
    do_reset();
    in_valid = 1'b1;
    in_word  = 16'hCCCC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_match_count", match_count, 0);
    check("midrst_match_found", match_found, 0);
    rst = 1'b1;
    hist.delete();
    pulses = 0;
    if (done === 1'b1) pulses++;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done !== 1'b0) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    @(posedge clk); #1;

    // Random words against the reference model, with gaps and resets.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      idle_cycles($urandom_range(0, 2));
      in_word = WORD_W'($urandom);
      model_word(in_word, e);
      exp_q.push_back(e);
      scan_word($sformatf("rnd%0d", n), in_word, got);
      check($sformatf("rnd%0d_sb_nonempty", n), exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        compare_result($sformatf("rnd%0d", n), got, e);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
